// File: rtl/shreg194_pkg.sv
// Shared op codes, chain mode encodings and FSM states for the sn74ls194 chain sequencer.
package shreg194_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_CLR  = 3'b001;
    localparam logic [2:0] OP_LOAD = 3'b010;
    localparam logic [2:0] OP_SHR  = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;
    localparam logic [2:0] OP_ROR  = 3'b101;
    localparam logic [2:0] OP_ROL  = 3'b110;
    localparam logic [2:0] OP_NOP2 = 3'b111;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

    // Rotates use the same chain mode as the matching shift; only the serial fill differs.
    function automatic logic [1:0] op_mode(input logic [2:0] op);
        case (op)
            OP_SHR, OP_ROR: return MODE_SHR;
            OP_SHL, OP_ROL: return MODE_SHL;
            default:        return MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/shreg194_cnt.sv
// Loadable down-counter; term flags the last cycle of a run (count == 1).
module shreg194_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] din,
    output logic [CNT_W-1:0] count,
    output logic             term
);

    always_ff @(posedge clk) begin
        if (clr)       count <= '0;
        else if (load) count <= din;
        else if (dec)  count <= count - CNT_W'(1);
    end

    assign term = (count == CNT_W'(1));

endmodule

// File: rtl/shreg194_ctrl.sv
// Command sequencer for a cascaded sn74ls194 chain (clear/load/shift/rotate by N).
// Define SHREG194_CTRL_VERIFY_EN to add the sticky err readback check after load/clear.
module shreg194_ctrl
    import shreg194_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_sin,
    output logic             done,
    output logic             reg_clr_n,
    output logic             reg_s1,
    output logic             reg_s0,
    output logic             reg_r,
    output logic             reg_l,
    output logic [WIDTH-1:0] reg_d,
`ifdef SHREG194_CTRL_VERIFY_EN
    output logic             err,
`endif
    input  logic [WIDTH-1:0] reg_q
);

    state_t           state;
    logic [2:0]       op_q;
    logic             sin_q;
    logic [1:0]       mode;
    logic             accept;
    logic             in_run;
    logic [CNT_W-1:0] count;
    logic             term;

    assign accept = cmd_valid && cmd_ready;
    assign in_run = (state == ST_RUN);
    assign reg_s1 = mode[1];
    assign reg_s0 = mode[0];

    shreg194_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk   (clk),
        .clr   (clr),
        .load  (accept),
        .dec   (in_run),
        .din   (cmd_cnt),
        .count (count),
        .term  (term)
    );

    // Outputs are registered from the next state, so each pin is valid for the whole cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
            reg_clr_n <= 1'b1;
            mode      <= MODE_HOLD;
            reg_d     <= '0;
            op_q      <= OP_NOP;
            sin_q     <= 1'b0;
        end else begin
            done      <= 1'b0;
            reg_clr_n <= 1'b1;
            mode      <= MODE_HOLD;
            reg_d     <= '0;
            cmd_ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        sin_q     <= cmd_sin;
                        if (cmd_op == OP_CLR) begin
                            state     <= ST_CLEAR;
                            reg_clr_n <= 1'b0;
                        end else if (cmd_op == OP_LOAD) begin
                            state <= ST_LOAD;
                            mode  <= MODE_LOAD;
                            reg_d <= cmd_data;
                        end else if (is_shift(cmd_op) && (cmd_cnt != '0)) begin
                            state <= ST_RUN;
                            mode  <= op_mode(cmd_op);
                        end else begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_CLEAR, ST_LOAD: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_RUN: begin
                    if (term) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        mode <= op_mode(op_q);
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    // Rotate fill comes straight from live q so the wrapped bit is the one about to fall off.
    always_comb begin
        reg_r = 1'b0;
        reg_l = 1'b0;
        if (in_run) begin
            case (op_q)
                OP_SHR:  reg_r = sin_q;
                OP_ROR:  reg_r = reg_q[WIDTH-1];
                OP_SHL:  reg_l = sin_q;
                OP_ROL:  reg_l = reg_q[0];
                default: ;
            endcase
        end
    end

`ifdef SHREG194_CTRL_VERIFY_EN
    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            data_q <= '0;
            err    <= 1'b0;
        end else if (accept) begin
            data_q <= cmd_data;
            err    <= 1'b0;
        end else if (state == ST_DONE) begin
            if ((op_q == OP_LOAD) && (reg_q != data_q)) err <= 1'b1;
            if ((op_q == OP_CLR) && (reg_q != '0))      err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_shreg194_ctrl.sv
// Bench for shreg194_ctrl driving a behavioural one-chip sn74ls194; scoreboard on done pulses.
module tb_shreg194_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             clr = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = 3'd0;
    logic [CNT_W-1:0] cmd_cnt = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_sin = 1'b0;
    logic             done;
    logic             reg_clr_n, reg_s1, reg_s0, reg_r, reg_l;
    logic [WIDTH-1:0] reg_d;
    logic [WIDTH-1:0] reg_q;
    logic [WIDTH-1:0] chain_q = '0;
    logic             ovr = 1'b0;
`ifdef SHREG194_CTRL_VERIFY_EN
    logic             err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shreg194_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_sin   (cmd_sin),
        .done      (done),
        .reg_clr_n (reg_clr_n),
        .reg_s1    (reg_s1),
        .reg_s0    (reg_s0),
        .reg_r     (reg_r),
        .reg_l     (reg_l),
        .reg_d     (reg_d),
`ifdef SHREG194_CTRL_VERIFY_EN
        .err       (err),
`endif
        .reg_q     (reg_q)
    );

    // One sn74ls194: s1s0 00 hold, 01 shift toward MSB (r in), 10 toward LSB (l in), 11 load.
    always @(posedge clk) begin
        if (!reg_clr_n) chain_q <= '0;
        else begin
            case ({reg_s1, reg_s0})
                2'b01:   chain_q <= {chain_q[2:0], reg_r};
                2'b10:   chain_q <= {reg_l, chain_q[3:1]};
                2'b11:   chain_q <= reg_d;
                default: chain_q <= chain_q;
            endcase
        end
    end
    assign reg_q = ovr ? 4'hF : chain_q;

    typedef struct {
        int         lat;
        logic [3:0] q;
        int         act;
        int         clrc;
        bit         chk_q;
    } exp_t;

    exp_t sb[$];
    logic [3:0] mq = '0;
    bit acc_pend = 0, abort_pend = 0, busy = 0, mon_en = 0;
    int cyc = 0, act = 0, clrc = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference: apply the command's effect N times with plain arithmetic on a 4-bit value.
    function automatic exp_t model(input logic [2:0] op, input int cnt, input logic [3:0] data,
                                   input logic sin, input logic [3:0] q0);
        exp_t e;
        int v;
        v = q0;
        e.chk_q = 1;
        e.act = 0;
        e.clrc = 0;
        e.lat = 1;
        case (op)
            3'd1: begin v = 0; e.lat = 2; e.clrc = 1; end
            3'd2: begin v = data; e.lat = 2; e.act = 1; end
            3'd3, 3'd4, 3'd5, 3'd6: begin
                e.lat = (cnt == 0) ? 1 : cnt + 1;
                e.act = cnt;
                for (int k = 0; k < cnt; k++) begin
                    case (op)
                        3'd3:    v = ((v * 2) + sin) % 16;
                        3'd4:    v = (v / 2) + (sin ? 8 : 0);
                        3'd5:    v = ((v * 2) % 16) + (v / 8);
                        default: v = (v / 2) + ((v % 2) * 8);
                    endcase
                end
            end
            default: ;
        endcase
        e.q = v[3:0];
        return e;
    endfunction

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) continue;
            if (abort_pend) begin
                abort_pend = 0;
                chk("abort_done", done, 0);
                chk("abort_mode", {reg_s1, reg_s0}, 0);
                chk("abort_ready", cmd_ready, 1);
                busy = 0;
                sb.delete();
                continue;
            end
            if (acc_pend) begin
                acc_pend = 0;
                busy = 1;
                cyc = 1;
                act = 0;
                clrc = 0;
            end else if (busy) cyc++;
            if (busy) begin
                if ({reg_s1, reg_s0} != 2'b00) act++;
                if (!reg_clr_n) clrc++;
                if (cmd_ready) chk("ready_while_busy", cmd_ready, 0);
                if (done) begin
                    if (sb.size() == 0) chk("done_unexpected", done, 0);
                    else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("latency", cyc, e.lat);
                        chk("mode_cycles", act, e.act);
                        chk("clear_cycles", clrc, e.clrc);
                        if (e.chk_q) chk("q_at_done", reg_q, e.q);
                    end
                    busy = 0;
                end
            end else begin
                chk("idle_done", done, 0);
                chk("idle_mode", {reg_s1, reg_s0}, 0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input int cnt, input logic [3:0] data,
                         input logic sin, input bit hold, input bit wait_done, input bit chk_q);
        int n;
        exp_t e;
        @(negedge clk);
        cmd_op = op;
        cmd_cnt = CNT_W'(cnt);
        cmd_data = data;
        cmd_sin = sin;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", cmd_ready, 1);
            cmd_valid = 1'b0;
            return;
        end
        e = model(op, cnt, data, sin, mq);
        e.chk_q = chk_q;
        mq = e.q;
        sb.push_back(e);
        acc_pend = 1;
        @(negedge clk);
        if (!wait_done) begin
            cmd_valid = 1'b0;
            return;
        end
        n = 0;
        while ((busy || acc_pend) && n < 300) begin
            if (hold) begin
                cmd_valid = 1'b1;
                cmd_op = 3'($urandom_range(1, 6));
                cmd_cnt = CNT_W'($urandom);
                cmd_data = 4'($urandom);
            end else cmd_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        cmd_valid = 1'b0;
        if (busy) chk("done_timeout", busy, 0);
    endtask

    initial begin : stim
        repeat (3) @(negedge clk);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_clr_n", reg_clr_n, 1);
        chk("rst_mode", {reg_s1, reg_s0}, 0);
        chk("rst_rl", {reg_r, reg_l}, 0);
        chk("rst_d", reg_d, 0);
        clr = 1'b0;
        mon_en = 1;

        issue(3'd1, 0, 4'h0, 0, 0, 1, 1);
        issue(3'd2, 0, 4'h5, 0, 0, 1, 1);
        issue(3'd3, 2, 4'h0, 0, 0, 1, 1);
        issue(3'd1, 0, 4'h0, 0, 0, 1, 1);
        issue(3'd4, 3, 4'h0, 1, 0, 1, 1);
        issue(3'd2, 0, 4'h1, 0, 0, 1, 1);
        issue(3'd5, 4, 4'h0, 0, 0, 1, 1);
        chk("ror_full_turn", chain_q, 4'h1);
        issue(3'd4, 0, 4'h0, 1, 1, 1, 1);
        issue(3'd7, 5, 4'h0, 1, 1, 1, 1);
        issue(3'd0, 0, 4'h0, 0, 0, 1, 1);
        issue(3'd5, 15, 4'h0, 0, 1, 1, 1);

        for (int i = 0; i < 40; i++)
            issue(3'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 4'($urandom),
                  1'($urandom), 1'($urandom), 1, 1);

        issue(3'd6, 8, 4'h0, 0, 0, 0, 1);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        abort_pend = 1;
        @(negedge clk);
        clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_abort_idle", cmd_ready, 1);
        issue(3'd1, 0, 4'h0, 0, 0, 1, 1);

`ifdef SHREG194_CTRL_VERIFY_EN
        ovr = 1'b1;
        issue(3'd2, 0, 4'h5, 0, 0, 1, 0);
        ovr = 1'b0;
        @(negedge clk);
        chk("err_bad_load", err, 1);
        issue(3'd2, 0, 4'h5, 0, 0, 1, 1);
        @(negedge clk);
        chk("err_good_load", err, 0);
        issue(3'd1, 0, 4'h0, 0, 0, 1, 1);
        @(negedge clk);
        chk("err_good_clear", err, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
